pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline stage register that replaces fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic, handshaked, 2-entry skid-buffered register. Upstream stages pack their control and data fields into one `WIDTH`-bit payload. The block provides:
- a registered, fully decoupled `in_ready`, so stalls do not form long combinational paths across stages;
- full one-per-cycle throughput;
- a flush that squashes in-flight instructions on branch or exception redirect.

---
 rtl/pipe_stage_elastic.sv | 91 +++++++++
 tb/tb_pipe_stage_elastic.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Generic handshaked pipeline stage register with a 2-entry skid buffer.
// in_ready, out_valid and count are flops so stalls never chain combinationally.
module pipe_stage_elastic #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  // Occupancy FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            count     <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
            count    <= 2'd2;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
            count    <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          count     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomised checks for pipe_stage_elastic
// (32-bit instance for directed tests, 70-bit instance for random traffic).
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 32-bit DUT
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  count;

  pipe_stage_elastic #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  // 70-bit DUT
  logic        r_reset = 1'b1;
  logic        r_flush = 1'b0;
  logic        r_in_valid = 1'b0;
  logic        r_in_ready;
  logic [69:0] r_in_data = '0;
  logic        r_out_valid;
  logic        r_out_ready = 1'b0;
  logic [69:0] r_out_data;
  logic [1:0]  r_count;

  pipe_stage_elastic #(.WIDTH(70)) rdut (
    .clk(clk), .reset(r_reset), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .count(r_count)
  );

  // Delivery counter and output-stability monitor for the 32-bit DUT
  int          delivered = 0;
  logic        hold = 1'b0;
  logic [31:0] held = '0;
  always @(posedge clk) begin
    if (hold) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        fails++;
        $display("FAIL stable: valid=%b data=%h required valid=1 data=%h",
                 out_valid, out_data, held);
      end
    end
    if (out_valid && out_ready) delivered++;
    hold = out_valid && !out_ready && !flush && !reset;
    held = out_data;
  end

  // Scoreboard for the 70-bit DUT
  logic [69:0] sb[$];
  logic        rand_on = 1'b0;
  logic [69:0] exp70;
  always @(posedge clk) begin
    if (rand_on) begin
      tests++;
      if (r_count !== 2'(sb.size())) begin
        fails++;
        $display("FAIL rnd_count: got %0d required %0d", r_count, sb.size());
      end
      if (r_out_valid && r_out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rnd_order: got %h required nothing", r_out_data);
        end else begin
          exp70 = sb.pop_front();
          if (r_out_data !== exp70) begin
            fails++;
            $display("FAIL rnd_order: got %h required %h", r_out_data, exp70);
          end
        end
      end
      if (r_in_valid && r_in_ready) sb.push_back(r_in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    step(); step();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", out_data, 32'd0);
    step();
    chk("rst_noacc", 32'(out_valid), 32'd0);
  endtask

  task automatic test_streaming();
    int base;
    out_ready = 1'b1;
    base = delivered;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      chk("str_valid", 32'(out_valid), 32'd1);
      chk("str_data", out_data, 32'(i));
      chk("str_count", 32'(count), 32'd1);
      chk("str_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("str_drain", 32'(out_valid), 32'd0);
    chk("str_deliv", 32'(delivered - base), 32'd16);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    chk("bp_cnt1", 32'(count), 32'd1);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    in_data = 32'hB;
    step();
    chk("bp_cnt2", 32'(count), 32'd2);
    chk("bp_rdy0", 32'(in_ready), 32'd0);
    chk("bp_dataA", out_data, 32'hA);
    in_data = 32'hC;
    step();
    chk("bp_full", 32'(count), 32'd2);
    chk("bp_holdA", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    chk("bp_dataB", out_data, 32'hB);
    chk("bp_cnt_rel", 32'(count), 32'd1);
    step();
    chk("bp_dataC", out_data, 32'hC);
    chk("bp_validC", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(count), 32'd0);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    chk("fl_full", 32'(count), 32'd2);
    flush = 1'b1; in_data = 32'h33;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    step();
    chk("fl_no33", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 32'h55;
    step();
    flush = 1'b1; in_data = 32'h66;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_drop", 32'(out_valid), 32'd0);
    step();
    chk("fl_drop2", 32'(count), 32'd0);
  endtask

  task automatic test_flush_fire();
    int base;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h44;
    step();
    in_valid = 1'b0;
    chk("ff_one", out_data, 32'h44);
    base = delivered;
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ff_empty", 32'(out_valid), 32'd0);
    chk("ff_deliv", 32'(delivered - base), 32'd1);
    step();
    chk("ff_once", 32'(delivered - base), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    r_reset = 1'b1;
    step(); step();
    r_reset = 1'b0;
    rand_on = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r_in_valid  = 1'($urandom_range(0, 1));
      r_out_ready = 1'($urandom_range(0, 1));
      r_in_data   = {6'($urandom), $urandom, $urandom};
      step();
    end
    r_in_valid = 1'b0; r_out_ready = 1'b1;
    step(); step(); step();
    rand_on = 1'b0;
    chk("rnd_drain", 32'(sb.size()), 32'd0);
    chk("rnd_cnt0", 32'(r_count), 32'd0);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_fire();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
